// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
//
// Multi-cycle RV32I main control unit. It sequences every instruction through
// FETCH -> DECODE -> (EXEC -> (MEMACC) -> WB | BRANCH | WB | TRAP) and drives
// the datapath strobes, the ALU class code and the funct bits ALU_CONTROL
// needs. An internal instruction register captures the word on the FETCH
// handshake so the instr input may change freely afterwards.
//
// Optional feature: define INSTR_COUNTER_EN to add the retired_count output, a
// CNT_W-bit wrapping count of instructions that completed (left WB, BRANCH or
// a store's MEMACC).
//
// Ports
//   CLK              in   clock, all state changes on the rising edge
//   RESET            in   synchronous active-high reset
//   instr[31:0]      in   instruction word from instruction memory
//   instr_valid      in   instr is valid (looked at in FETCH only)
//   mem_ready        in   data-memory access completes (MEMACC only)
//   branch_cond      in   ALU branch-condition result
//   ALUOp[2:0]       out  000 R, 001 branch, 010 add/ld/st, 011 I-ALU, 100 LUI/AUIPC
//   instruction_bits out  {funct7[5], funct3} for ALU_CONTROL
//   PCWrite          out  PC update strobe
//   IRWrite          out  instruction-register load strobe
//   MemRead/MemWrite out  data-memory strobes
//   RegWrite         out  register-file write strobe
//   ResultSrc[1:0]   out  write-back source: 00 ALU, 01 memory, 10 PC+4
//   state[2:0]       out  current state, used for datapath mux selects
//   illegal          out  an undecodable opcode was seen (held until RESET)
//   retired_count    out  retired-instruction counter (INSTR_COUNTER_EN only)
// ---------------------------------------------------------------------------
module main_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic [2:0]  ALUOp,
    output logic [3:0]  instruction_bits,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  state,
    output logic        illegal
`ifdef INSTR_COUNTER_EN
    ,
    output logic [CNT_W-1:0] retired_count
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEMACC = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_IALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_UPPER,
        CLS_BRANCH,
        CLS_JAL,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_R     = 3'b000;
    localparam logic [2:0] ALU_BR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_IALU  = 3'b011;
    localparam logic [2:0] ALU_UPPER = 3'b100;

    localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Only the fields the controller decodes are kept; the remaining IR bits
    // belong to the datapath's own instruction register.
    state_t       state_q;
    state_t       state_d;
    logic [6:0]   ir_opcode;
    logic [2:0]   ir_funct3;
    logic         ir_bit30;
    logic         illegal_q;
    instr_class_t cls;

    logic         ir_load;
    logic [2:0]   alu_op_d;
    logic [3:0]   bits_d;
    logic         pc_write_d;
    logic         ir_write_d;
    logic         mem_read_d;
    logic         mem_write_d;
    logic         reg_write_d;
    logic [1:0]   result_src_d;
    logic         retire;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    function automatic instr_class_t classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:             return CLS_R;
            OP_IALU:          return CLS_IALU;
            OP_LOAD:          return CLS_LOAD;
            OP_STORE:         return CLS_STORE;
            OP_LUI, OP_AUIPC: return CLS_UPPER;
            OP_BRANCH:        return CLS_BRANCH;
            OP_JAL:           return CLS_JAL;
            default:          return CLS_ILLEGAL;
        endcase
    endfunction

    assign cls = classify(ir_opcode);

    // IR is captured on the same handshake that raises IRWrite.
    assign ir_load = (state_q == FETCH) && instr_valid;

    // ------------------------------------------------------------------------
    // State and instruction register
    // ------------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others, whatever order the statements appear in.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= FETCH;
            ir_opcode <= '0;
            ir_funct3 <= '0;
            ir_bit30  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_d == TRAP);
            if (ir_load) begin
                ir_opcode <= instr[6:0];
                ir_funct3 <= instr[14:12];
                ir_bit30  <= instr[30];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        alu_op_d     = ALU_R;
        bits_d       = 4'b0000;
        pc_write_d   = 1'b0;
        ir_write_d   = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        result_src_d = RES_ALU;
        retire       = 1'b0;

        case (state_q)
            FETCH: begin
                alu_op_d = ALU_ADD;
                if (instr_valid) begin
                    ir_write_d = 1'b1;
                    pc_write_d = 1'b1;
                    state_d    = DECODE;
                end
            end

            DECODE: begin
                alu_op_d = ALU_ADD;
                case (cls)
                    CLS_BRANCH:  state_d = BRANCH;
                    CLS_JAL:     state_d = WB;
                    CLS_ILLEGAL: state_d = TRAP;
                    default:     state_d = EXEC;
                endcase
            end

            EXEC: begin
                case (cls)
                    CLS_R: begin
                        alu_op_d = ALU_R;
                        bits_d   = {ir_bit30, ir_funct3};
                    end
                    CLS_IALU: begin
                        alu_op_d = ALU_IALU;
                        // Bit 30 of an I-type word is immediate data except
                        // for the shift-right pair, where it picks srli/srai.
                        bits_d   = (ir_funct3 == F3_SHIFT_RIGHT) ?
                                   {ir_bit30, ir_funct3} : {1'b0, ir_funct3};
                    end
                    CLS_LOAD, CLS_STORE: alu_op_d = ALU_ADD;
                    CLS_UPPER:           alu_op_d = ALU_UPPER;
                    default:             alu_op_d = ALU_R;
                endcase
                state_d = (cls == CLS_LOAD || cls == CLS_STORE) ? MEMACC : WB;
            end

            MEMACC: begin
                mem_read_d  = (cls == CLS_LOAD);
                mem_write_d = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_LOAD) begin
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                end
            end

            WB: begin
                reg_write_d = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
                if (cls == CLS_LOAD) begin
                    result_src_d = RES_MEM;
                end else if (cls == CLS_JAL) begin
                    result_src_d = RES_PC4;
                    pc_write_d   = 1'b1;
                end
            end

            BRANCH: begin
                alu_op_d   = ALU_BR;
                bits_d     = {1'b0, ir_funct3};
                pc_write_d = branch_cond;
                retire     = 1'b1;
                state_d    = FETCH;
            end

            TRAP: begin
                state_d = TRAP;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Strobes are gated by RESET directly so an aborted instruction cannot
    // write anything in the cycle reset is asserted.
    assign PCWrite          = pc_write_d  & ~RESET;
    assign IRWrite          = ir_write_d  & ~RESET;
    assign MemRead          = mem_read_d  & ~RESET;
    assign MemWrite         = mem_write_d & ~RESET;
    assign RegWrite         = reg_write_d & ~RESET;
    assign ALUOp            = alu_op_d;
    assign instruction_bits = bits_d;
    assign ResultSrc        = result_src_d;
    assign state            = state_q;
    assign illegal          = illegal_q;

    // ------------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------------
`ifdef INSTR_COUNTER_EN
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired_count = retired_q;
`else
    // Keeps the width parameter referenced when the counter is compiled out.
    localparam int unused_cnt_w = CNT_W;
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_control_fsm
//
// Directed bench for main_control_fsm. Each cycle the full output set is
// packed into one word and compared against a hand-written expectation.
// The DUT runs with CNT_W=4 so the retired counter wrap is reachable when
// INSTR_COUNTER_EN is defined.
// ---------------------------------------------------------------------------
module tb_main_control_fsm;

    localparam int TB_CNT_W = 4;

    // strobe groups, ordered {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}
    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_FETCH = 5'b11000;
    localparam logic [4:0] S_MR    = 5'b00100;
    localparam logic [4:0] S_MW    = 5'b00010;
    localparam logic [4:0] S_RW    = 5'b00001;
    localparam logic [4:0] S_PC    = 5'b10000;
    localparam logic [4:0] S_JAL   = 5'b10001;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_ready;
    logic        branch_cond;
    logic [2:0]  ALUOp;
    logic [3:0]  instruction_bits;
    logic        PCWrite;
    logic        IRWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [2:0]  state;
    logic        illegal;
`ifdef INSTR_COUNTER_EN
    logic [TB_CNT_W-1:0] retired_count;
`endif

    int n_vec = 0;
    int n_miss = 0;
    int exp_retired = 0;

    always #5 CLK = ~CLK;

    main_control_fsm #(.CNT_W(TB_CNT_W)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .mem_ready        (mem_ready),
        .branch_cond      (branch_cond),
        .ALUOp            (ALUOp),
        .instruction_bits (instruction_bits),
        .PCWrite          (PCWrite),
        .IRWrite          (IRWrite),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .RegWrite         (RegWrite),
        .ResultSrc        (ResultSrc),
        .state            (state),
        .illegal          (illegal)
`ifdef INSTR_COUNTER_EN
        ,
        .retired_count    (retired_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {state, ALUOp, instruction_bits, strobes, ResultSrc, illegal}
    function automatic logic [31:0] outs();
        return {14'd0, state, ALUOp, instruction_bits,
                PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ResultSrc, illegal};
    endfunction

    function automatic logic [31:0] ev(input logic [2:0] st, input logic [2:0] aop,
                                       input logic [3:0] bits, input logic [4:0] strb,
                                       input logic [1:0] rs, input logic ill);
        return {14'd0, st, aop, bits, strb, rs, ill};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check_count();
`ifdef INSTR_COUNTER_EN
        check("retired_count", 32'(retired_count), 32'(exp_retired % (1 << TB_CNT_W)));
`endif
    endtask

    // R / I-ALU / LUI / AUIPC: FETCH, DECODE, EXEC, WB, back to FETCH.
    // With hold set, instr_valid stays high and instr is trashed after FETCH.
    task automatic run_alu(input string tag, input logic [31:0] w,
                           input logic [2:0] aop, input logic [3:0] bits, input logic hold);
        instr = w;
        instr_valid = 1'b1;
        #1 check({tag, " fetch"}, outs(), ev(3'd0, 3'b010, 4'b0000, S_FETCH, 2'b00, 1'b0));
        tick();
        if (hold) instr = 32'hFFFF_FFFF;
        else      instr_valid = 1'b0;
        #1 check({tag, " decode"}, outs(), ev(3'd1, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        tick();
        #1 check({tag, " exec"}, outs(), ev(3'd2, aop, bits, S_NONE, 2'b00, 1'b0));
        tick();
        instr_valid = 1'b0;
        #1 check({tag, " wb"}, outs(), ev(3'd4, 3'b000, 4'b0000, S_RW, 2'b00, 1'b0));
        exp_retired++;
        tick();
        #1 check({tag, " done"}, outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        check_count();
    endtask

    task automatic run_branch(input string tag, input logic [31:0] w,
                              input logic cond, input logic [3:0] bits);
        instr = w;
        instr_valid = 1'b1;
        branch_cond = cond;
        #1 check({tag, " fetch"}, outs(), ev(3'd0, 3'b010, 4'b0000, S_FETCH, 2'b00, 1'b0));
        tick();
        instr_valid = 1'b0;
        #1 check({tag, " decode"}, outs(), ev(3'd1, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        tick();
        #1 check({tag, " branch"}, outs(),
                 ev(3'd5, 3'b001, bits, cond ? S_PC : S_NONE, 2'b00, 1'b0));
        exp_retired++;
        tick();
        branch_cond = 1'b0;
        #1 check({tag, " done"}, outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        check_count();
    endtask

    // Store up to its first MEMACC cycle, mem_ready low.
    task automatic store_to_memacc(input string tag);
        instr = 32'h0011_2023;
        instr_valid = 1'b1;
        mem_ready = 1'b0;
        #1 check({tag, " fetch"}, outs(), ev(3'd0, 3'b010, 4'b0000, S_FETCH, 2'b00, 1'b0));
        tick();
        instr_valid = 1'b0;
        #1 check({tag, " decode"}, outs(), ev(3'd1, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        tick();
        #1 check({tag, " exec"}, outs(), ev(3'd2, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        tick();
        #1 check({tag, " memacc"}, outs(), ev(3'd3, 3'b000, 4'b0000, S_MW, 2'b00, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1;
        instr = 32'h0031_00B3;
        instr_valid = 1'b1;
        mem_ready = 1'b0;
        branch_cond = 1'b0;

        // Reset: FETCH, strobes held off even though instr_valid is high.
        tick();
        tick();
        #1 check("reset", outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        check_count();
        RESET = 1'b0;
        instr_valid = 1'b0;
        tick();
        #1 check("idle fetch", outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));

        // Register and immediate ALU classes.
        run_alu("add",   32'h0031_00B3, 3'b000, 4'b0000, 1'b0);
        run_alu("sub",   32'h4031_00B3, 3'b000, 4'b1000, 1'b1);
        run_alu("srai",  32'h4030_D093, 3'b011, 4'b1101, 1'b0);
        run_alu("addi",  32'h4001_0093, 3'b011, 4'b0000, 1'b0);
        run_alu("lui",   32'h1234_50B7, 3'b100, 4'b0000, 1'b0);
        run_alu("auipc", 32'h0000_1097, 3'b100, 4'b0000, 1'b1);

        // Load with three wait cycles; mem_ready high outside MEMACC is ignored.
        instr = 32'h0001_2083;
        instr_valid = 1'b1;
        mem_ready = 1'b1;
        #1 check("lw fetch", outs(), ev(3'd0, 3'b010, 4'b0000, S_FETCH, 2'b00, 1'b0));
        tick();
        instr_valid = 1'b0;
        #1 check("lw decode", outs(), ev(3'd1, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        tick();
        #1 check("lw exec", outs(), ev(3'd2, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_ready = 1'b0;
            #1 check("lw wait", outs(), ev(3'd3, 3'b000, 4'b0000, S_MR, 2'b00, 1'b0));
        end
        tick();
        mem_ready = 1'b1;
        #1 check("lw ready", outs(), ev(3'd3, 3'b000, 4'b0000, S_MR, 2'b00, 1'b0));
        tick();
        mem_ready = 1'b0;
        #1 check("lw wb", outs(), ev(3'd4, 3'b000, 4'b0000, S_RW, 2'b01, 1'b0));
        exp_retired++;
        tick();
        #1 check("lw done", outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        check_count();

        // Store completing on its first MEMACC cycle.
        store_to_memacc("sw");
        mem_ready = 1'b1;
        #1 check("sw ready", outs(), ev(3'd3, 3'b000, 4'b0000, S_MW, 2'b00, 1'b0));
        exp_retired++;
        tick();
        mem_ready = 1'b0;
        #1 check("sw done", outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        check_count();

        // Branches: taken, not taken, funct7 bit forced to 0.
        run_branch("beq taken", 32'h0020_8463, 1'b1, 4'b0000);
        run_branch("beq not",   32'h0020_8463, 1'b0, 4'b0000);
        run_branch("bne b30",   32'h4020_9463, 1'b1, 4'b0001);

        // JAL: FETCH, DECODE, WB with PC+4 write-back.
        instr = 32'h0080_00EF;
        instr_valid = 1'b1;
        #1 check("jal fetch", outs(), ev(3'd0, 3'b010, 4'b0000, S_FETCH, 2'b00, 1'b0));
        tick();
        instr_valid = 1'b0;
        #1 check("jal decode", outs(), ev(3'd1, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        tick();
        #1 check("jal wb", outs(), ev(3'd4, 3'b000, 4'b0000, S_JAL, 2'b10, 1'b0));
        exp_retired++;
        tick();
        #1 check("jal done", outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        check_count();

        // Enough further retirements to carry the 4-bit counter past its wrap.
        for (int i = 0; i < 6; i++) begin
            run_branch("wrap", 32'h0020_8463, i[0], 4'b0000);
        end

        // Reset during a store's MEMACC: MemWrite drops at once, FETCH after the edge.
        store_to_memacc("sw abort");
        RESET = 1'b1;
        #1 check("sw abort gate", outs(), ev(3'd3, 3'b000, 4'b0000, S_NONE, 2'b00, 1'b0));
        tick();
        exp_retired = 0;
        #1 check("sw abort fetch", outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        check_count();
        RESET = 1'b0;

        // Illegal opcode: TRAP held with instr_valid high, cleared by RESET.
        instr = 32'hFFFF_FFFF;
        instr_valid = 1'b1;
        #1 check("trap fetch", outs(), ev(3'd0, 3'b010, 4'b0000, S_FETCH, 2'b00, 1'b0));
        tick();
        #1 check("trap decode", outs(), ev(3'd1, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        for (int i = 0; i < 10; i++) begin
            tick();
            #1 check("trap hold", outs(), ev(3'd6, 3'b000, 4'b0000, S_NONE, 2'b00, 1'b1));
        end
        RESET = 1'b1;
        tick();
        #1 check("trap reset", outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));
        RESET = 1'b0;
        instr_valid = 1'b0;
        tick();
        #1 check("trap cleared", outs(), ev(3'd0, 3'b010, 4'b0000, S_NONE, 2'b00, 1'b0));

        // An unlisted opcode (SYSTEM) also traps.
        instr = 32'h0000_0073;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        #1 check("ecall trap", outs(), ev(3'd6, 3'b000, 4'b0000, S_NONE, 2'b00, 1'b1));
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        exp_retired = 0;
        check_count();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 The module SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-003 The module SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port instr, input, 32 bits: the RV32I instruction word from instruction memory.
REQ-005 The module SHALL have port instr_valid, input, 1 bit: instr is valid this cycle.
REQ-006 The module SHALL have port mem_ready, input, 1 bit: the data-memory access completes this cycle.
REQ-007 The module SHALL have port branch_cond, input, 1 bit: the ALU branch-condition result.
REQ-008 The module SHALL have port ALUOp, output, 3 bits: class code for ALU_CONTROL (000 R, 001 branch, 010 add/ld/st, 011 I-ALU, 100 LUI/AUIPC).
REQ-009 The module SHALL have port instruction_bits, output, 4 bits: {funct7[5], funct3} for ALU_CONTROL.
REQ-010 The module SHALL have port PCWrite, output, 1 bit: PC update strobe.
REQ-011 The module SHALL have port IRWrite, output, 1 bit: instruction-register load strobe.
REQ-012 The module SHALL have ports MemRead and MemWrite, output, 1 bit each: data-memory strobes.
REQ-013 The module SHALL have port RegWrite, output, 1 bit: register-file write strobe.
REQ-014 The module SHALL have port ResultSrc, output, 2 bits: write-back source (00 ALU, 01 memory, 10 PC+4).
REQ-015 The module SHALL have port state, output, 3 bits: current state, used by the datapath for mux selects.
REQ-016 The module SHALL have port illegal, output, 1 bit: an undecodable opcode was seen.

Function
REQ-017 The FSM SHALL have these states: FETCH=0, DECODE=1, EXEC=2, MEMACC=3, WB=4, BRANCH=5, TRAP=6; encoding 7 SHALL go to FETCH.
REQ-018 FETCH SHALL behave as follows.
- If instr_valid=0: stay in FETCH.
- If instr_valid=1: IRWrite=1, PCWrite=1, ALUOp=010, load the internal IR from instr, and go to DECODE.
REQ-019 DECODE SHALL classify IR[6:0] and branch as follows.
- 0110011, 0010011, 0000011, 0100011, 0110111 or 0010111 -> EXEC.
- 1100011 -> BRANCH.
- 1101111 -> WB.
- Any other opcode -> TRAP.
REQ-020 EXEC SHALL last 1 cycle and drive ALUOp by class: R 000, I-ALU 011, load/store 010, LUI/AUIPC 100; it SHALL then go to MEMACC for load/store and to WB otherwise.
REQ-021 instruction_bits SHALL be driven as follows.
- R-type: {IR[30], IR[14:12]}.
- I-ALU: {IR[30], IR[14:12]} only when funct3=101, else {0, IR[14:12]}.
- Branch: {0, IR[14:12]}.
- All other classes and states: 0000.
REQ-022 MEMACC SHALL hold MemRead (load) or MemWrite (store) high every cycle until mem_ready=1.
- On mem_ready, a load SHALL go to WB and a store SHALL go to FETCH.
REQ-023 WB SHALL last 1 cycle with RegWrite=1 and then go to FETCH.
- ResultSrc SHALL be 01 for loads and 10 for JAL, with PCWrite=1 for JAL; ResultSrc SHALL be 00 for every other class.
REQ-024 BRANCH SHALL last 1 cycle with ALUOp=001 and PCWrite=branch_cond, then go to FETCH.
REQ-025 TRAP SHALL hold illegal=1 with all strobes 0 until RESET.
REQ-026 Any output not specified for the current state SHALL be 0, except ALUOp, which SHALL be 010 in FETCH and DECODE.
REQ-027 instr_valid outside FETCH and mem_ready outside MEMACC SHALL be ignored.
REQ-028 Latency from FETCH with instr_valid=1 back to FETCH SHALL be as follows.
- R, I-ALU, LUI/AUIPC: 4 cycles.
- Store: 4 cycles plus memory waits.
- Load: 5 cycles plus memory waits.
- Branch and JAL: 3 cycles.

Reset
REQ-029 While RESET=1 at a clock edge, the FSM SHALL reset as follows.
- state SHALL become FETCH, IR SHALL become 0 and illegal SHALL become 0.
- All strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) SHALL be forced to 0 combinationally while RESET is high.
REQ-030 RESET asserted mid-operation, including in MEMACC or TRAP, SHALL abort the instruction with no further strobes, and FETCH SHALL follow the next edge.

Configuration
REQ-031 When macro INSTR_COUNTER_EN is defined, the module SHALL add output retired_count (CNT_W bits).
- It SHALL reset to 0.
- It SHALL increment by 1 on the cycle each instruction leaves WB, BRANCH or store-MEMACC.
- It SHALL wrap from 2^CNT_W-1 to 0.
REQ-032 When INSTR_COUNTER_EN is not defined, neither the port nor the counter logic SHALL exist; all other behaviour is identical.

Verification
REQ-033 instr=0x003100B3 (add), instr_valid=1 -> state sequence 0,1,2,4,0; EXEC: ALUOp=000, instruction_bits=0000; WB: RegWrite=1, ResultSrc=00.
REQ-034 instr=0x403100B3 (sub) -> EXEC: instruction_bits=1000. instr=0x4030D093 (srai) -> ALUOp=011, bits=1101. instr=0x40010093 (addi) -> bits=0000.
REQ-035 instr=0x00012083 (lw), mem_ready low 3 cycles -> MemRead high 4 cycles; then WB with RegWrite=1, ResultSrc=01; 8 cycles total.
REQ-036 instr=0x00208463 (beq): branch_cond=1 -> BRANCH: ALUOp=001, PCWrite=1; branch_cond=0 -> PCWrite=0; both cases return to FETCH.
REQ-037 instr=0xFFFFFFFF -> TRAP, illegal=1 held 10 cycles despite instr_valid; RESET -> FETCH, illegal=0.
REQ-038 RESET during MEMACC of a store -> MemWrite=0 immediately, FETCH next cycle; with INSTR_COUNTER_EN, retired_count=0.
